tb_status_periph: RTL and testbench
===================================

TB_STATUS_PERIPH -- requirements
Module: tb_status_periph

Interface
REQ-001 SHALL have parameter STDOUT_ADDR, default 32'h1000_0000, byte-print register address.
REQ-002 SHALL have parameter STATUS_ADDR, default 32'h2000_0000, test pass/fail register address.
REQ-003 SHALL have parameter EXIT_ADDR, default 32'h2000_0004, exit-code register address.
REQ-004 SHALL have parameter CYCLE_ADDR, default 32'h1500_1000, cycle-counter register address.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, stdout character FIFO depth (power of 2, >=2).
REQ-006 SHALL have ports clk_i in 1 clock; rst_i in 1 reset. One clock; reset is synchronous and active-high.
REQ-007 SHALL have data_req_i in 1, data_addr_i in 32, data_we_i in 1, data_be_i in 4, data_wdata_i in 32: core data request.
REQ-008 SHALL have data_gnt_o out 1, data_rvalid_o out 1, data_rdata_o out 32, data_err_o out 1: response.
REQ-009 SHALL have char_valid_o out 1, char_data_o out 8, char_ready_i in 1: stdout byte stream to printer.
REQ-010 SHALL have tests_passed_o out 1, tests_failed_o out 1, exit_valid_o out 1, exit_value_o out 32: status to testbench top.

Function
REQ-011 SHALL assert data_gnt_o combinationally = data_req_i, except 0 for a stdout write while FIFO full.
REQ-012 SHALL assert data_rvalid_o exactly one cycle after each grant, one rvalid per grant, back-to-back grants allowed.
REQ-013 SHALL return rdata = cycle counter for read of CYCLE_ADDR; 0 for reads of any other mapped address.
REQ-014 SHALL set data_err_o with rvalid for any granted access to unmapped address; no state change; rdata 0.
REQ-015 SHALL push data_wdata_i[7:0] into FIFO on granted write to STDOUT_ADDR with data_be_i[0]=1; be[0]=0 -> granted, no push.
REQ-016 SHALL present FIFO head on char_data_o, char_valid_o = FIFO non-empty; pop when valid & ready.
REQ-017 SHALL support simultaneous push and pop when not full; occupancy unchanged; order preserved, pointers wrap modulo FIFO_DEPTH.
REQ-018 SHALL, when full, stall stdout write (gnt 0) even if pop occurs same cycle; grant next cycle.
REQ-019 SHALL set tests_passed_o sticky on granted write to STATUS_ADDR with wdata 32'd123456789.
REQ-020 SHALL set tests_failed_o sticky on granted write to STATUS_ADDR with wdata 32'd1; other values ignored.
REQ-021 SHALL latch passed/failed first-wins: once either set, further STATUS writes ignored.
REQ-022 SHALL set exit_valid_o sticky and capture exit_value_o = wdata on first granted write to EXIT_ADDR; later writes ignored.
REQ-023 SHALL register status outputs: visible the cycle after the grant.
REQ-024 SHALL increment 32-bit cycle counter every cycle out of reset, wrapping 32'hFFFF_FFFF -> 0.
REQ-025 SHALL clear counter to 0 on granted write to CYCLE_ADDR (counts from 1 the next cycle); read-same-cycle returns pre-clear value.
REQ-026 SHALL ignore data_be_i for STATUS/EXIT/CYCLE writes (full-word).

Reset
REQ-027 SHALL, with rst_i high at a clock edge, clear: FIFO empty, char_valid_o 0, rvalid 0, err 0, rdata 0, counter 0, passed/failed/exit_valid 0, exit_value 0.
REQ-028 SHALL, on reset mid-operation, drop outstanding rvalid and FIFO contents; data_gnt_o follows REQ-011 combinationally regardless of reset.

Verification
REQ-029 Write 'H','i' to STDOUT_ADDR, char_ready_i=1 -> char_data_o 8'h48 then 8'h69, one each cycle, rvalid one cycle after each grant.
REQ-030 char_ready_i=0, 9 stdout writes (depth 8) -> 8 granted, 9th gnt=0 until one pop; then granted; order intact.
REQ-031 Write 123456789 to STATUS_ADDR then 1 -> tests_passed_o=1 next cycle, tests_failed_o stays 0.
REQ-032 Write 32'h5 to EXIT_ADDR, then 32'h0 -> exit_valid_o=1, exit_value_o=32'h5 held.
REQ-033 Read CYCLE_ADDR 10 cycles after reset release -> rdata 32'd10 (±1 per counter edge definition fixed in bench); write clears, read 3 cycles later -> 3.
REQ-034 Read 32'h3000_0000 -> rvalid=1, err=1, rdata 0; assert rst_i with FIFO holding 3 bytes -> char_valid_o 0 next cycle.

Source files
------------

// File: rtl/tb_status_periph.sv
// Simulation status peripheral: stdout byte FIFO, pass/fail/exit latches and a
// free-running cycle counter behind a simple req/gnt/rvalid data port.
module tb_status_periph #(
  parameter logic [31:0] STDOUT_ADDR = 32'h1000_0000,
  parameter logic [31:0] STATUS_ADDR = 32'h2000_0000,
  parameter logic [31:0] EXIT_ADDR   = 32'h2000_0004,
  parameter logic [31:0] CYCLE_ADDR  = 32'h1500_1000,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        char_valid_o,
  output logic [7:0]  char_data_o,
  input  logic        char_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [31:0] PASS_CODE = 32'd123456789;
  localparam logic [31:0] FAIL_CODE = 32'd1;

  logic hit_stdout, hit_status, hit_exit, hit_cycle, mapped;
  logic wr, push, pop, full, empty;
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic [7:0] mem [FIFO_DEPTH];
  logic [31:0] cycle_cnt;
  logic unused_be;

  assign hit_stdout = (data_addr_i == STDOUT_ADDR);
  assign hit_status = (data_addr_i == STATUS_ADDR);
  assign hit_exit   = (data_addr_i == EXIT_ADDR);
  assign hit_cycle  = (data_addr_i == CYCLE_ADDR);
  assign mapped     = hit_stdout | hit_status | hit_exit | hit_cycle;
  assign unused_be  = ^data_be_i[3:1];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // A full FIFO stalls stdout writes even if a pop happens this same cycle.
  assign data_gnt_o = data_req_i & ~(hit_stdout & data_we_i & full);
  assign wr   = data_gnt_o & data_we_i;
  assign push = wr & hit_stdout & data_be_i[0];
  assign pop  = ~empty & char_ready_i;

  assign char_valid_o = ~empty;
  assign char_data_o  = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= data_wdata_i[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{PTR_W{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{PTR_W{1'b0}}, 1'b1};
    end
  end

  // Response stage: one rvalid per grant, one cycle later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_rvalid_o <= 1'b0;
      data_err_o    <= 1'b0;
      data_rdata_o  <= '0;
    end else begin
      data_rvalid_o <= data_gnt_o;
      data_err_o    <= data_gnt_o & ~mapped;
      data_rdata_o  <= (data_gnt_o & ~data_we_i & hit_cycle) ? cycle_cnt : 32'd0;
    end
  end

  // The clearing write's own cycle counts as cycle 0, so the next cycle reads 1.
  always_ff @(posedge clk_i) begin
    if (rst_i)                 cycle_cnt <= '0;
    else if (wr && hit_cycle)  cycle_cnt <= 32'd1;
    else                       cycle_cnt <= cycle_cnt + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tests_passed_o <= 1'b0;
      tests_failed_o <= 1'b0;
      exit_valid_o   <= 1'b0;
      exit_value_o   <= '0;
    end else if (wr) begin
      if (hit_status && !tests_passed_o && !tests_failed_o) begin
        if (data_wdata_i == PASS_CODE)      tests_passed_o <= 1'b1;
        else if (data_wdata_i == FAIL_CODE) tests_failed_o <= 1'b1;
      end
      if (hit_exit && !exit_valid_o) begin
        exit_valid_o <= 1'b1;
        exit_value_o <= data_wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_tb_status_periph.sv
// Self-checking bench for tb_status_periph: directed scenarios plus a randomized
// run checked against a queue-based reference model.
module tb_tb_status_periph;

  localparam logic [31:0] STDOUT = 32'h1000_0000;
  localparam logic [31:0] STATUS = 32'h2000_0000;
  localparam logic [31:0] EXITA  = 32'h2000_0004;
  localparam logic [31:0] CYCLE  = 32'h1500_1000;
  localparam logic [31:0] BAD    = 32'h3000_0000;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst, req, we, ready;
  logic [31:0] addr, wdata;
  logic [3:0] be;
  logic gnt, rvalid, err, cv, passed, failed, ev;
  logic [31:0] rdata, eval;
  logic [7:0] cd;

  always #5 clk = ~clk;

  tb_status_periph #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .data_req_i(req), .data_addr_i(addr), .data_we_i(we), .data_be_i(be),
    .data_wdata_i(wdata),
    .data_gnt_o(gnt), .data_rvalid_o(rvalid), .data_rdata_o(rdata), .data_err_o(err),
    .char_valid_o(cv), .char_data_o(cd), .char_ready_i(ready),
    .tests_passed_o(passed), .tests_failed_o(failed),
    .exit_valid_o(ev), .exit_value_o(eval)
  );

  // Reference model state
  logic [7:0] q[$];
  int cyc = 0, cref = 0;
  bit m_pass, m_fail, m_ev;
  logic [31:0] m_eval;
  bit e_rv, e_err;
  logic [31:0] e_rdata;
  int pass_cnt = 0, total = 0;

  function automatic bit is_mapped(input logic [31:0] a);
    return (a == STDOUT) || (a == STATUS) || (a == EXITA) || (a == CYCLE);
  endfunction

  function automatic bit exp_gnt();
    return req && !(we && addr == STDOUT && q.size() == DEPTH);
  endfunction

  // Advance one clock, updating the model from the currently driven inputs.
  task automatic tick();
    bit g, push, pop;
    logic [31:0] pre;
    g = exp_gnt();
    pre = 32'(cyc - cref);
    push = g && we && addr == STDOUT && be[0];
    pop = ready && q.size() > 0;
    e_rv = !rst && g;
    e_err = !rst && g && !is_mapped(addr);
    e_rdata = (!rst && g && !we && addr == CYCLE) ? pre : 32'd0;
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      m_pass = 0; m_fail = 0; m_ev = 0; m_eval = 0;
      cref = cyc;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(wdata[7:0]);
      if (g && we) begin
        if (addr == STATUS && !m_pass && !m_fail) begin
          if (wdata == 32'd123456789) m_pass = 1;
          else if (wdata == 32'd1) m_fail = 1;
        end
        if (addr == EXITA && !m_ev) begin
          m_ev = 1; m_eval = wdata;
        end
        if (addr == CYCLE) cref = cyc - 1;
      end
    end
    #1;
  endtask

  task automatic set_req(input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] d);
    req = 1'b1; addr = a; we = w; be = b; wdata = d;
  endtask

  task automatic idle();
    req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b0; idle();
    tick(); tick();
    total++; if ({cv, rvalid, err} !== 3'b000) $display("FAIL reset_resp got %b want 000", {cv, rvalid, err}); else pass_cnt++;
    total++; if (rdata !== 32'd0) $display("FAIL reset_rdata got %h want 0", rdata); else pass_cnt++;
    total++; if ({passed, failed, ev} !== 3'b000) $display("FAIL reset_status got %b want 000", {passed, failed, ev}); else pass_cnt++;
    total++; if (eval !== 32'd0) $display("FAIL reset_exit_value got %h want 0", eval); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_hi();
    ready = 1'b1;
    set_req(STDOUT, 1'b1, 4'b0001, 32'h48); #1;
    total++; if (gnt !== 1'b1) $display("FAIL hi_gnt_h got %b want 1", gnt); else pass_cnt++;
    tick();
    total++; if ({rvalid, cv} !== 2'b11) $display("FAIL hi_rv_h got %b want 11", {rvalid, cv}); else pass_cnt++;
    total++; if (cd !== 8'h48) $display("FAIL hi_char_h got %h want 48", cd); else pass_cnt++;
    set_req(STDOUT, 1'b1, 4'b0001, 32'h69); #1;
    total++; if (gnt !== 1'b1) $display("FAIL hi_gnt_i got %b want 1", gnt); else pass_cnt++;
    tick();
    total++; if ({rvalid, cv} !== 2'b11) $display("FAIL hi_rv_i got %b want 11", {rvalid, cv}); else pass_cnt++;
    total++; if (cd !== 8'h69) $display("FAIL hi_char_i got %h want 69", cd); else pass_cnt++;
    set_req(STDOUT, 1'b1, 4'b1110, 32'h55); tick();
    total++; if ({rvalid, cv} !== 2'b10) $display("FAIL be0_nopush got %b want 10", {rvalid, cv}); else pass_cnt++;
    idle(); tick();
    total++; if ({rvalid, cv} !== 2'b00) $display("FAIL hi_idle got %b want 00", {rvalid, cv}); else pass_cnt++;
  endtask

  task automatic test_fifo_full();
    int n;
    ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_req(STDOUT, 1'b1, 4'hF, 32'h41 + 32'(i)); #1;
      total++; if (gnt !== (i < 8) || gnt !== exp_gnt()) $display("FAIL full_gnt[%0d] got %b want %b", i, gnt, (i < 8)); else pass_cnt++;
      tick();
    end
    ready = 1'b1; #1;
    total++; if (gnt !== 1'b0) $display("FAIL full_pop_same_cycle_gnt got %b want 0", gnt); else pass_cnt++;
    tick();
    ready = 1'b0; #1;
    total++; if (gnt !== 1'b1) $display("FAIL full_after_pop_gnt got %b want 1", gnt); else pass_cnt++;
    tick();
    idle(); ready = 1'b1;
    total++; if (cd !== 8'h42) $display("FAIL full_head got %h want 42", cd); else pass_cnt++;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      total++; if (cv !== 1'b1 || cd !== q[0]) $display("FAIL drain[%0d] got %b/%h want 1/%h", n, cv, cd, q[0]); else pass_cnt++;
      tick(); n++;
    end
    total++; if (cv !== 1'b0 || n != 8) $display("FAIL drain_end got valid %b after %0d want 0 after 8", cv, n); else pass_cnt++;
  endtask

  task automatic test_status();
    set_req(STATUS, 1'b1, 4'hF, 32'd77); tick();
    total++; if ({passed, failed} !== 2'b00) $display("FAIL status_other got %b want 00", {passed, failed}); else pass_cnt++;
    set_req(STATUS, 1'b1, 4'h0, 32'd123456789); #1;
    total++; if (passed !== 1'b0) $display("FAIL status_not_early got %b want 0", passed); else pass_cnt++;
    tick();
    total++; if ({passed, failed} !== 2'b10) $display("FAIL status_pass got %b want 10", {passed, failed}); else pass_cnt++;
    set_req(STATUS, 1'b1, 4'hF, 32'd1); tick(); idle(); tick();
    total++; if ({passed, failed} !== 2'b10) $display("FAIL status_first_wins got %b want 10", {passed, failed}); else pass_cnt++;
  endtask

  task automatic test_exit();
    set_req(EXITA, 1'b1, 4'h1, 32'h5); tick();
    total++; if (ev !== 1'b1 || eval !== 32'h5) $display("FAIL exit_first got %b/%h want 1/5", ev, eval); else pass_cnt++;
    set_req(EXITA, 1'b1, 4'hF, 32'h0); tick(); idle();
    total++; if (ev !== 1'b1 || eval !== 32'h5) $display("FAIL exit_held got %b/%h want 1/5", ev, eval); else pass_cnt++;
  endtask

  task automatic test_cycle();
    rst = 1'b1; idle(); tick(); rst = 1'b0;
    repeat (10) tick();
    set_req(CYCLE, 1'b0, 4'h0, 32'h0); tick();
    total++; if (rvalid !== 1'b1 || rdata !== 32'd10 || rdata !== e_rdata) $display("FAIL cycle_after_reset got %0d want 10", rdata); else pass_cnt++;
    set_req(CYCLE, 1'b1, 4'h0, 32'hDEAD_BEEF); tick();
    idle(); tick(); tick();
    set_req(CYCLE, 1'b0, 4'h0, 32'h0); tick(); idle();
    total++; if (rdata !== 32'd3 || err !== 1'b0) $display("FAIL cycle_after_clear got %0d/%b want 3/0", rdata, err); else pass_cnt++;
  endtask

  task automatic test_unmapped();
    set_req(BAD, 1'b0, 4'hF, 32'h0); #1;
    total++; if (gnt !== 1'b1) $display("FAIL unmapped_gnt got %b want 1", gnt); else pass_cnt++;
    tick();
    total++; if ({rvalid, err} !== 2'b11 || rdata !== 32'd0) $display("FAIL unmapped_read got %b/%h want 11/0", {rvalid, err}, rdata); else pass_cnt++;
    set_req(BAD, 1'b1, 4'hF, 32'd123456789); tick();
    set_req(STATUS, 1'b0, 4'hF, 32'h0); tick(); idle();
    total++; if ({passed, err, rvalid} !== 3'b001 || rdata !== 32'd0) $display("FAIL mapped_read got %b/%h want 001/0", {passed, err, rvalid}, rdata); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(STDOUT, 1'b1, 4'h1, 32'h61 + 32'(i)); tick();
    end
    total++; if (cv !== 1'b1 || cd !== 8'h61) $display("FAIL mid_fill got %b/%h want 1/61", cv, cd); else pass_cnt++;
    set_req(STDOUT, 1'b1, 4'h1, 32'h7A); rst = 1'b1; #1;
    total++; if (gnt !== 1'b1) $display("FAIL gnt_in_reset got %b want 1", gnt); else pass_cnt++;
    tick();
    total++; if ({cv, rvalid} !== 2'b00) $display("FAIL mid_reset got %b want 00", {cv, rvalid}); else pass_cnt++;
    rst = 1'b0; idle(); tick();
  endtask

  task automatic test_random();
    logic [31:0] a;
    rst = 1'b1; idle(); tick(); rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 6))
        0, 1, 2: a = STDOUT;
        3: a = STATUS;
        4: a = EXITA;
        5: a = CYCLE;
        default: a = BAD;
      endcase
      req = ($urandom_range(0, 3) != 0);
      addr = a;
      we = (a == CYCLE) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      be = 4'($urandom);
      case ($urandom_range(0, 7))
        0: wdata = 32'd123456789;
        1: wdata = 32'd1;
        default: wdata = $urandom;
      endcase
      ready = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 99) == 0);
      #1;
      total++; if (gnt !== exp_gnt()) $display("FAIL rnd_gnt[%0d] got %b want %b", i, gnt, exp_gnt()); else pass_cnt++;
      tick();
      total++; if (rvalid !== e_rv || err !== e_err || rdata !== e_rdata) $display("FAIL rnd_resp[%0d] got %b%b/%h want %b%b/%h", i, rvalid, err, rdata, e_rv, e_err, e_rdata); else pass_cnt++;
      total++; if (cv !== (q.size() > 0) || (q.size() > 0 && cd !== q[0])) $display("FAIL rnd_char[%0d] got %b/%h want %0d queued", i, cv, cd, q.size()); else pass_cnt++;
      total++; if ({passed, failed, ev} !== {m_pass, m_fail, m_ev} || eval !== m_eval) $display("FAIL rnd_status[%0d] got %b/%h want %b/%h", i, {passed, failed, ev}, eval, {m_pass, m_fail, m_ev}, m_eval); else pass_cnt++;
    end
    rst = 1'b0; idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ready = 1'b0; idle();
    @(posedge clk); #1;
    test_reset();
    test_hi();
    test_fifo_full();
    test_status();
    test_exit();
    test_cycle();
    test_unmapped();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
